three_way_toom_cook_seq: RTL and testbench
==========================================

// Module: three_way_toom_cook_seq
// PURPOSE
//  Parametrised sequential 3-way Toom-Cook carry-less (GF(2)[x]) multiplier: c = a * b, XOR accumulation.
//  Both operands split on a common limb width L; six limb products, Karatsuba-style, instead of nine.
//  Each product is a digit-serial shift-and-XOR engine running in parallel; start/busy/done handshake.
//  Drop-in multiply core for binary-field crypto datapaths of the TTech large-integer library.
// PARAMETERS
//  A_W      192  width of operand a (>=3)
//  B_W      150  width of operand b (>=3)
//  DIGIT_W  1    a-limb bits consumed per engine per cycle, 1 <= DIGIT_W <= L
//  Derived (localparam): L = ceil(max(A_W,B_W)/3); N = ceil(L/DIGIT_W); P_W = 2L-1; C_W = A_W+B_W
// PORTS
//  clk    in   1        rising-edge clock
//  rst_n  in   1        asynchronous, active-low reset
//  start  in   1        request; sampled only in IDLE
//  a      in   A_W      operand a, captured on accepted start
//  b      in   B_W      operand b, captured on accepted start
//  busy   out  1        high in MUL and FINISH
//  done   out  1        one-cycle pulse, c valid
//  c      out  C_W      product; held until next accepted start (MSB always 0)
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, busy=0, done=0, c=0, all accumulators/counters 0.
//  Operands zero-extended to 3L; ai = a[iL +: L], bi = b[iL +: L], i=0..2.
//  Engines: P0=a0*b0, P1=a1*b1, P2=a2*b2, P01=(a0^a1)*(b0^b1), P02=(a0^a2)*(b0^b2), P12=(a1^a2)*(b1^b2).
//  FSM: IDLE -> MUL on start; MUL -> FINISH after N digit cycles; FINISH -> IDLE unconditionally.
//  IDLE+start edge: latch limb sums into shift regs, clear six P_W accumulators, digit counter=0, busy=1.
//  MUL edge k (k=0..N-1): each engine XORs, for j<DIGIT_W with bit kDIGIT_W+j < L set,
//   (b-operand << (k*DIGIT_W+j)) into its accumulator; counter++; bits beyond L treated as 0.
//  FINISH edge: c <= c0 ^ c1<<L ^ c2<<2L ^ c3<<3L ^ c4<<4L, truncated to C_W, where
//   c0=P0, c1=P01^P0^P1, c2=P02^P0^P1^P2, c3=P12^P1^P2, c4=P2; done=1 for this one cycle.
//  Latency: start sampled at edge 0 -> done high after edge N+1 (defaults: 65 cycles).
//  start in MUL or FINISH ignored (no queuing); operands a/b may change freely after acceptance.
//  Next start accepted the cycle after done (state back in IDLE); min issue interval N+2 cycles.
//  rst_n asserted mid-operation: immediate abort, all state as reset, no done pulse.
//  c and done change only on the FINISH edge or reset; c stable across IDLE.
// TESTING
//  Defaults, a=1, b=1, start one cycle -> done exactly 65 cycles later, c=1, busy high for 65 cycles.
//  a=3, b=3 -> c=5 (carry-less); a=2^192-1, b=1 -> c=a; a=2^191, b=2^149 -> c=2^340 only.
//  1000 random a,b vs. bitwise clmul model, for defaults, DIGIT_W=4 (N=16), and A_W=B_W=17 (L=6, padded limbs).
//  start held high throughout and pulsed during MUL -> exactly one result per accepted start, c unchanged until FINISH.
//  rst_n low at MUL cycle 30 -> busy=0, c=0, no done; next start with a=7,b=5 -> c=27, full latency.
//  Back-to-back: start asserted in FINISH ignored, re-asserted in IDLE accepted; c holds first result until second done.

Source files
------------

// File: rtl/three_way_toom_cook_seq.sv
// Sequential 3-way Toom-Cook carry-less multiplier: six digit-serial GF(2)[x] limb
// products computed in parallel, then recombined into c = a * b.
module three_way_toom_cook_seq #(
  parameter int A_W     = 192,
  parameter int B_W     = 150,
  parameter int DIGIT_W = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic               busy,
  output logic               done,
  output logic [A_W+B_W-1:0] c
);

  localparam int MAX_W = (A_W > B_W) ? A_W : B_W;
  localparam int L     = (MAX_W + 2) / 3;
  localparam int N     = (L + DIGIT_W - 1) / DIGIT_W;
  localparam int P_W   = 2 * L - 1;
  localparam int C_W   = A_W + B_W;
  localparam int E_W   = 3 * L;
  localparam int R_W   = 6 * L;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, MUL, FINISH} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [E_W-1:0]   a_ext, b_ext;
  logic [L-1:0]     a_sum [6];
  logic [L-1:0]     b_sum [6];
  logic [L-1:0]     asr   [6];
  logic [P_W-1:0]   bsh   [6];
  logic [P_W-1:0]   acc   [6];

  assign a_ext = E_W'(a);
  assign b_ext = E_W'(b);

  // Engine order: P0, P1, P2, P01, P02, P12
  always_comb begin
    a_sum[0] = a_ext[0 +: L];
    a_sum[1] = a_ext[L +: L];
    a_sum[2] = a_ext[2*L +: L];
    a_sum[3] = a_ext[0 +: L] ^ a_ext[L +: L];
    a_sum[4] = a_ext[0 +: L] ^ a_ext[2*L +: L];
    a_sum[5] = a_ext[L +: L] ^ a_ext[2*L +: L];
    b_sum[0] = b_ext[0 +: L];
    b_sum[1] = b_ext[L +: L];
    b_sum[2] = b_ext[2*L +: L];
    b_sum[3] = b_ext[0 +: L] ^ b_ext[L +: L];
    b_sum[4] = b_ext[0 +: L] ^ b_ext[2*L +: L];
    b_sum[5] = b_ext[L +: L] ^ b_ext[2*L +: L];
  end

  // The a-limb shifts right and the b-operand shifts left each digit, so bit j of asr
  // always pairs with bsh << j; zero-fill makes bits beyond L contribute nothing.
  function automatic logic [P_W-1:0] digit_step(input logic [P_W-1:0] acc_in,
                                                input logic [L-1:0]   asr_in,
                                                input logic [P_W-1:0] bsh_in);
    logic [P_W-1:0] r;
    r = acc_in;
    for (int j = 0; j < DIGIT_W; j++) begin
      if (asr_in[j]) r = r ^ (bsh_in << j);
    end
    return r;
  endfunction

  function automatic logic [C_W-1:0] combine(input logic [P_W-1:0] p0,
                                             input logic [P_W-1:0] p1,
                                             input logic [P_W-1:0] p2,
                                             input logic [P_W-1:0] p01,
                                             input logic [P_W-1:0] p02,
                                             input logic [P_W-1:0] p12);
    logic [R_W-1:0] r;
    r = R_W'(p0)
      ^ (R_W'(p01 ^ p0 ^ p1) << L)
      ^ (R_W'(p02 ^ p0 ^ p1 ^ p2) << (2 * L))
      ^ (R_W'(p12 ^ p1 ^ p2) << (3 * L))
      ^ (R_W'(p2) << (4 * L));
    return r[C_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      c     <= '0;
      cnt   <= '0;
      for (int e = 0; e < 6; e++) begin
        asr[e] <= '0;
        bsh[e] <= '0;
        acc[e] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int e = 0; e < 6; e++) begin
              asr[e] <= a_sum[e];
              bsh[e] <= P_W'(b_sum[e]);
              acc[e] <= '0;
            end
            cnt   <= '0;
            busy  <= 1'b1;
            state <= MUL;
          end
        end
        MUL: begin
          for (int e = 0; e < 6; e++) begin
            acc[e] <= digit_step(acc[e], asr[e], bsh[e]);
            asr[e] <= asr[e] >> DIGIT_W;
            bsh[e] <= bsh[e] << DIGIT_W;
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(N - 1)) state <= FINISH;
        end
        FINISH: begin
          c     <= combine(acc[0], acc[1], acc[2], acc[3], acc[4], acc[5]);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_three_way_toom_cook_seq.sv
// Bench for three_way_toom_cook_seq at default parameters: vector table, random
// operands against a bitwise clmul model, and handshake/reset corner sequences.
module tb_three_way_toom_cook_seq;

  localparam int A_W = 192;
  localparam int B_W = 150;
  localparam int C_W = A_W + B_W;
  localparam int N   = 64;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [A_W-1:0] a = '0;
  logic [B_W-1:0] b = '0;
  logic           busy, done;
  logic [C_W-1:0] c;

  int             tests = 0;
  int             fails = 0;
  logic [C_W-1:0] exp_q [$];
  logic [C_W-1:0] prev_c = '0;

  typedef struct {
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic [C_W-1:0] c;
    string          name;
  } vec_t;
  vec_t tbl [6];

  three_way_toom_cook_seq dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .c    (c)
  );

  always #5 clk = ~clk;

  function automatic logic [C_W-1:0] clmul(input logic [A_W-1:0] x, input logic [B_W-1:0] y);
    logic [C_W-1:0] r;
    r = '0;
    for (int i = 0; i < B_W; i++) if (y[i]) r = r ^ (C_W'(x) << i);
    return r;
  endfunction

  function automatic logic [A_W-1:0] rand_a();
    logic [A_W-1:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r = (r << 32) | A_W'($urandom());
    return r;
  endfunction

  function automatic logic [B_W-1:0] rand_b();
    logic [A_W-1:0] r;
    r = rand_a();
    return r[B_W-1:0];
  endfunction

  task automatic check_c(input string name, input logic [C_W-1:0] act, input logic [C_W-1:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic check_int(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Scoreboard: every done pulse pops one expected result; c may only move on done or reset.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done with c=%h expected no done", c);
      end else begin
        check_c("result", c, exp_q.pop_front());
      end
    end
    if (c !== prev_c) begin
      tests++;
      if (done !== 1'b1 && rst_n !== 1'b0) begin
        fails++;
        $display("FAIL c_stable: got c=%h without done expected %h", c, prev_c);
      end
    end
    prev_c = c;
  end

  // mode 0: start dropped; 1: start held high; 2: start pulsed in MUL; 3: start raised in FINISH and left high
  task automatic finish_op(input string name, input int mode);
    int lat, bcnt;
    lat  = 0;
    bcnt = 0;
    @(negedge clk);
    start = (mode == 1);
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
      if (mode != 0) begin
        a = rand_a();
        b = rand_b();
      end
      start = (mode == 1) || (mode == 2 && (lat == 10 || lat == 30)) || (mode == 3 && lat >= N);
    end
    if (mode != 3) start = 1'b0;
    check_int({name, "_latency"}, lat, N + 1);
    check_int({name, "_busy_cycles"}, bcnt, N + 1);
    check_int({name, "_busy_at_done"}, int'(busy), 0);
  endtask

  task automatic issue(input logic [A_W-1:0] ai, input logic [B_W-1:0] bi,
                       input logic [C_W-1:0] ec, input string name, input int mode);
    @(negedge clk);
    a = ai;
    b = bi;
    start = 1'b1;
    exp_q.push_back(ec);
    finish_op(name, mode);
  endtask

  initial begin
    logic [A_W-1:0] ra;
    logic [B_W-1:0] rb;

    tbl[0] = '{A_W'(1), B_W'(1), C_W'(1), "one_x_one"};
    tbl[1] = '{A_W'(3), B_W'(3), C_W'(5), "three_x_three"};
    tbl[2] = '{{A_W{1'b1}}, B_W'(1), C_W'({A_W{1'b1}}), "max_a_x_one"};
    tbl[3] = '{A_W'(1) << 191, B_W'(1) << 149, C_W'(1) << 340, "top_bits"};
    tbl[4] = '{{A_W{1'b1}}, {B_W{1'b1}}, clmul({A_W{1'b1}}, {B_W{1'b1}}), "ones_x_ones"};
    tbl[5] = '{A_W'(0), {B_W{1'b1}}, C_W'(0), "zero_a"};

    repeat (3) @(negedge clk);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_done", int'(done), 0);
    check_c("reset_c", c, '0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) issue(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].name, 0);

    for (int i = 0; i < 300; i++) begin
      ra = rand_a();
      rb = rand_b();
      if (i % 4 == 0) rb = rb & B_W'(32'hffff_ffff);
      issue(ra, rb, clmul(ra, rb), "random", 0);
    end

    issue(A_W'(192'h1234_5678_9abc), B_W'(150'h0f0f_a5a5), clmul(A_W'(192'h1234_5678_9abc), B_W'(150'h0f0f_a5a5)), "start_held", 1);
    repeat (N + 8) @(negedge clk);
    check_int("held_no_reissue", int'(busy), 0);

    ra = rand_a();
    rb = rand_b();
    issue(ra, rb, clmul(ra, rb), "start_pulsed", 2);
    repeat (4) @(negedge clk);

    // Back-to-back: start raised in FINISH is ignored, then taken in IDLE with new operands.
    ra = rand_a();
    rb = rand_b();
    issue(ra, rb, clmul(ra, rb), "b2b_first", 3);
    a = A_W'(11);
    b = B_W'(13);
    exp_q.push_back(C_W'(127));
    finish_op("b2b_second", 0);
    repeat (3) @(negedge clk);

    // Abort mid-operation with reset.
    @(negedge clk);
    a = rand_a();
    b = rand_b();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_int("abort_busy", int'(busy), 0);
    check_int("abort_done", int'(done), 0);
    check_c("abort_c", c, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(A_W'(7), B_W'(5), C_W'(27), "after_abort", 0);
    repeat (N + 4) @(negedge clk);

    check_int("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
